// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the lab5 pattern-RAM access controller.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 4;
  localparam int DEPTH      = 2 ** RAM_ADDR_W;

  // Which requester issued the read whose data returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RD   = 2'd1,
    OWN_DISP = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_access_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus rising-edge detector for one button.
// All three flops reset to 1 so a button held through reset never produces
// an event once reset is released.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic s1_q, s2_q, hist_q;

  // Synchronize the asynchronous button and remember the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~hist_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: cursor/editor sequencer and three-way arbiter for the
// single-port 512x4 pattern RAM. Optional cursor readback is enabled by
// defining CURSOR_READBACK_EN; the default build omits it.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_write,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [DATA_W-1:0] sw,
  output logic [ADDR_W-1:0] cursor,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wr_pending,
  output logic [DATA_W-1:0] cur_data,
  output logic              cur_valid
);

  logic              wr_ev, inc_ev, dec_ev;
  logic [DATA_W-1:0] sw_s1_q, sw_s2_q;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_pending_q, wr_pending_d;
  logic              d_starved_q, d_starved_d;
  owner_e            owner_q, owner_d;
  logic              rd_pending;
  logic              d_req, w_win, r_win, d_win;

  btn_sync_edge u_sync_wr  (.clk(clk), .rst_n(rst_n), .btn_i(btn_write), .rise_o(wr_ev));
  btn_sync_edge u_sync_inc (.clk(clk), .rst_n(rst_n), .btn_i(btn_inc),   .rise_o(inc_ev));
  btn_sync_edge u_sync_dec (.clk(clk), .rst_n(rst_n), .btn_i(btn_dec),   .rise_o(dec_ev));

  // Switch bits only need synchronizing, no edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Arbiter: a starved display wins outright, otherwise W > R > D.
  always_comb begin
    d_req       = disp_req & rst_n;
    d_win       = d_req & (d_starved_q | (~wr_pending_q & ~rd_pending));
    w_win       = wr_pending_q & ~d_win;
    r_win       = rd_pending & ~wr_pending_q & ~d_win;
    d_starved_d = d_req & ~d_win;
    owner_d     = d_win ? OWN_DISP : (r_win ? OWN_RD : OWN_NONE);
    ram_addr    = cursor_q;
    if (d_win)      ram_addr = disp_addr;
    else if (w_win) ram_addr = wr_addr_q;
  end

  // Cursor moves wrap naturally; simultaneous inc and dec cancel.
  always_comb begin
    cursor_d = cursor_q;
    if (inc_ev && !dec_ev)      cursor_d = cursor_q + 1'b1;
    else if (dec_ev && !inc_ev) cursor_d = cursor_q - 1'b1;
    wr_pending_d = wr_ev | (wr_pending_q & ~w_win);
  end

  // Control state: cursor, queue flag, fairness flag, read owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_q     <= '0;
      wr_pending_q <= 1'b0;
      d_starved_q  <= 1'b0;
      owner_q      <= OWN_NONE;
    end else begin
      cursor_q     <= cursor_d;
      wr_pending_q <= wr_pending_d;
      d_starved_q  <= d_starved_d;
      owner_q      <= owner_d;
    end
  end

  // Write entry payload; captures the cursor before this cycle's move.
  always_ff @(posedge clk) begin
    if (wr_ev) begin
      wr_addr_q <= cursor_q;
      wr_data_q <= sw_s2_q;
    end
  end

`ifdef CURSOR_READBACK_EN
  logic              init_q, rd_pending_q, cur_valid_q, rd_trig;
  logic [DATA_W-1:0] cur_data_q;

  assign rd_trig = ~init_q | (inc_ev ^ dec_ev) | w_win;

  // Readback tracking; a trigger during the grant cycle keeps rd_pending set,
  // which marks the following return as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      cur_valid_q  <= 1'b0;
      cur_data_q   <= '0;
    end else begin
      init_q       <= 1'b1;
      rd_pending_q <= rd_trig | (rd_pending_q & ~r_win);
      if (rd_trig) begin
        cur_valid_q <= 1'b0;
      end else if (owner_q == OWN_RD && !rd_pending_q) begin
        cur_valid_q <= 1'b1;
        cur_data_q  <= ram_rdata;
      end
    end
  end

  assign rd_pending = rd_pending_q;
  assign cur_data   = cur_data_q;
  assign cur_valid  = cur_valid_q;
`else
  assign rd_pending = 1'b0;
  assign cur_data   = '0;
  assign cur_valid  = 1'b0;
`endif

  assign cursor      = cursor_q;
  assign wr_pending  = wr_pending_q;
  assign disp_gnt    = d_win;
  assign ram_we      = w_win;
  assign ram_wdata   = wr_data_q;
  assign disp_rvalid = (owner_q == OWN_DISP);
  assign disp_rdata  = ram_rdata;

endmodule
